// File: rtl/pcie_egress_pkg.sv
// Shared definitions for the PCIe egress arbiter: stream widths, port limit
// and the arbiter FSM state type.
package pcie_egress_pkg;

    localparam int AXIS_DATA_W = 64;
    localparam int AXIS_KEEP_W = 8;
    localparam int MAX_PORTS   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry AXI-Stream register slice with ready pass-through: a load and
// a drain in the same cycle sustain one beat per cycle.
module axis_reg_slice #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    logic              m_valid_reg;
    logic [DATA_W-1:0] m_data_reg;

    // Room exists when empty, or when the current beat leaves this edge.
    assign s_ready = !m_valid_reg || m_ready;
    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
        end else if (s_ready) begin
            m_valid_reg <= s_valid;
            if (s_valid) begin
                m_data_reg <= s_data;
            end
        end
    end

endmodule

// File: rtl/pcie_egress_arbiter.sv
// Packet-locked arbiter sharing the 64-bit PCIe egress stream between requesters.
// Define PCIE_EGRESS_ARB_STRICT_PRIO_EN for fixed priority; default is round-robin.
module pcie_egress_arbiter
    import pcie_egress_pkg::*;
#(
    parameter int NUM_PORTS = 2
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_PORTS-1:0]             S_AXIS_TVALID,
    output logic [NUM_PORTS-1:0]             S_AXIS_TREADY,
    input  logic [AXIS_DATA_W*NUM_PORTS-1:0] S_AXIS_TDATA,
    input  logic [AXIS_KEEP_W*NUM_PORTS-1:0] S_AXIS_TKEEP,
    input  logic [NUM_PORTS-1:0]             S_AXIS_TLAST,
    output logic                             M_AXIS_TVALID,
    input  logic                             M_AXIS_TREADY,
    output logic [AXIS_DATA_W-1:0]           M_AXIS_TDATA,
    output logic [AXIS_KEEP_W-1:0]           M_AXIS_TKEEP,
    output logic                             M_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]             GRANT,
    output logic                             BUSY
);

    localparam int PTR_W  = $clog2(NUM_PORTS);
    localparam int BEAT_W = AXIS_DATA_W + AXIS_KEEP_W + 1;

    generate
        if (NUM_PORTS < 2 || NUM_PORTS > MAX_PORTS) begin : g_bad_num_ports
            $error("pcie_egress_arbiter: NUM_PORTS must be in 2..4");
        end
    endgenerate

    arb_state_t           state_reg;
    logic [NUM_PORTS-1:0] grant_reg;
    logic [PTR_W-1:0]     grant_idx_reg;
    logic                 busy_reg;
    logic [PTR_W-1:0]     win_idx;
    logic [BEAT_W-1:0]    port_beat [NUM_PORTS];
    logic [BEAT_W-1:0]    sel_beat;
    logic [BEAT_W-1:0]    out_beat;
    logic                 slice_ready;
    logic                 beat_accept;

`ifdef PCIE_EGRESS_ARB_STRICT_PRIO_EN
    function automatic logic [PTR_W-1:0] pick_winner(input logic [NUM_PORTS-1:0] valid);
        logic [PTR_W-1:0] win;
        win = '0;
        // Scan downward so the lowest valid index is the last one written.
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (valid[k]) begin
                win = PTR_W'(k);
            end
        end
        return win;
    endfunction

    assign win_idx = pick_winner(S_AXIS_TVALID);
`else
    logic [PTR_W-1:0] rr_ptr_reg;

    function automatic logic [PTR_W-1:0] pick_winner(input logic [NUM_PORTS-1:0] valid,
                                                     input logic [PTR_W-1:0]     ptr);
        logic [PTR_W-1:0] win;
        logic             found;
        int               idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_PORTS) begin
                idx = idx - NUM_PORTS;
            end
            if (!found && valid[idx]) begin
                win   = PTR_W'(idx);
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign win_idx = pick_winner(S_AXIS_TVALID, rr_ptr_reg);
`endif

    // Grant is zero outside LOCKED, so gating ready by it also covers IDLE.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign port_beat[gi] = {S_AXIS_TLAST[gi],
                                    S_AXIS_TKEEP[gi*AXIS_KEEP_W +: AXIS_KEEP_W],
                                    S_AXIS_TDATA[gi*AXIS_DATA_W +: AXIS_DATA_W]};
            assign S_AXIS_TREADY[gi] = grant_reg[gi] & slice_ready;
        end
    endgenerate

    assign sel_beat    = port_beat[grant_idx_reg];
    assign beat_accept = |(S_AXIS_TVALID & S_AXIS_TREADY);

    axis_reg_slice #(
        .DATA_W (BEAT_W)
    ) u_out_slice (
        .clk     (ACLK),
        .rst     (ARESET),
        .s_valid (beat_accept),
        .s_ready (slice_ready),
        .s_data  (sel_beat),
        .m_valid (M_AXIS_TVALID),
        .m_data  (out_beat),
        .m_ready (M_AXIS_TREADY)
    );

    assign {M_AXIS_TLAST, M_AXIS_TKEEP, M_AXIS_TDATA} = out_beat;
    assign GRANT = grant_reg;
    assign BUSY  = busy_reg;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_reg     <= IDLE;
            grant_reg     <= '0;
            grant_idx_reg <= '0;
            busy_reg      <= 1'b0;
`ifndef PCIE_EGRESS_ARB_STRICT_PRIO_EN
            rr_ptr_reg    <= '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (|S_AXIS_TVALID) begin
                        state_reg     <= LOCKED;
                        grant_reg     <= NUM_PORTS'(1) << win_idx;
                        grant_idx_reg <= win_idx;
                        busy_reg      <= 1'b1;
                    end
                end
                LOCKED: begin
                    // Only the TLAST beat releases the lock; stalls just wait.
                    if (beat_accept && sel_beat[BEAT_W-1]) begin
                        state_reg <= IDLE;
                        grant_reg <= '0;
                        busy_reg  <= 1'b0;
`ifndef PCIE_EGRESS_ARB_STRICT_PRIO_EN
                        rr_ptr_reg <= (grant_idx_reg == PTR_W'(NUM_PORTS - 1)) ?
                                      '0 : grant_idx_reg + 1'b1;
`endif
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    grant_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

endmodule
